// File: rtl/line_fill_adapter.sv
// Bridges a wide cache line port to a narrow burst memory port: fills assemble
// BURSTS incoming beats into one line, writebacks slice a latched line into beats.
module line_fill_adapter #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64,
   parameter int BURSTS      = LINE_WIDTH / BURST_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   read_i,
   input  logic                   write_i,
   input  logic [31:0]            address_i,
   input  logic [LINE_WIDTH-1:0]  line_i,
   output logic [LINE_WIDTH-1:0]  line_o,
   output logic                   resp_o,
   output logic                   read_o,
   output logic                   write_o,
   output logic [31:0]            address_o,
   output logic [BURST_WIDTH-1:0] burst_o,
   input  logic [BURST_WIDTH-1:0] burst_i,
   input  logic                   resp_i
);

   localparam int CNT_W = (BURSTS > 1) ? $clog2(BURSTS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURSTS - 1);
   // Line-offset bits of the byte address are cleared so memory sees whole lines.
   localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_WIDTH / 8) - 32'd1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] WBACK = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]            state;
   logic [CNT_W-1:0]      beat;
   logic [31:0]           addr_q;
   logic [LINE_WIDTH-1:0] wb_line;
   logic [LINE_WIDTH-1:0] fill_line;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         beat      <= '0;
         addr_q    <= '0;
         wb_line   <= '0;
         fill_line <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (write_i) begin
                  wb_line <= line_i;
                  addr_q  <= address_i & ALIGN_MASK;
                  beat    <= '0;
                  state   <= WBACK;
               end else if (read_i) begin
                  addr_q <= address_i & ALIGN_MASK;
                  beat   <= '0;
                  state  <= FILL;
               end
            end
            FILL: begin
               if (resp_i) begin
                  fill_line[beat*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                  // The counter stops on the last beat instead of wrapping.
                  if (beat == LAST_BEAT) state <= DONE;
                  else                   beat  <= beat + 1'b1;
               end
            end
            WBACK: begin
               if (resp_i) begin
                  if (beat == LAST_BEAT) state <= DONE;
                  else                   beat  <= beat + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode registered state, so reset clears them without a clock.
   assign read_o    = (state == FILL);
   assign write_o   = (state == WBACK);
   assign resp_o    = (state == DONE);
   assign address_o = addr_q;
   assign line_o    = fill_line;
   assign burst_o   = (state == WBACK) ? wb_line[beat*BURST_WIDTH +: BURST_WIDTH] : '0;

endmodule

// File: tb/tb_line_fill_adapter.sv
// Directed bench for line_fill_adapter: stimulus pushes expected completions and
// writeback beats into queues; a negedge monitor pops and compares them.
module tb_line_fill_adapter;

   localparam int LW = 256;
   localparam int BW = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          read_i, write_i, resp_i;
   logic [31:0]   address_i;
   logic [LW-1:0] line_i;
   logic [BW-1:0] burst_i;
   logic [LW-1:0] line_o;
   logic          resp_o, read_o, write_o;
   logic [31:0]   address_o;
   logic [BW-1:0] burst_o;

   line_fill_adapter #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .BURSTS(4)) dut (
      .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i),
      .address_i(address_i), .line_i(line_i), .line_o(line_o),
      .resp_o(resp_o), .read_o(read_o), .write_o(write_o),
      .address_o(address_o), .burst_o(burst_o), .burst_i(burst_i),
      .resp_i(resp_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]   addr;
      logic [LW-1:0] line;
   } exp_t;

   exp_t          done_q[$];
   logic [BW-1:0] beat_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            n_resp  = 0;
   int            n_issued = 0;
   logic [LW-1:0] last_fill = '0;
   exp_t          mon_e;
   logic [BW-1:0] mon_b;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   // Monitor: compares writeback beats as memory accepts them and every completion.
   always @(negedge clk) begin
      if (write_o && resp_i) begin
         if (beat_q.size() == 0) check("wb_beat_unexpected", 1, 0);
         else begin
            mon_b = beat_q.pop_front();
            check("wb_beat", burst_o, mon_b);
         end
      end
      if (resp_o) begin
         n_resp++;
         if (done_q.size() == 0) check("resp_unexpected", 1, 0);
         else begin
            mon_e = done_q.pop_front();
            check("done_addr", address_o, mon_e.addr);
            check("done_line", line_o, mon_e.line);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_fill(input logic [31:0] addr, input logic [31:0] exp_addr,
                             input logic [LW-1:0] data);
      read_i    = 1'b1;
      address_i = addr;
      done_q.push_back('{exp_addr, data});
      last_fill = data;
      n_issued++;
      tick();
      read_i = 1'b0;
      check("fill_read_o", read_o, 1);
      check("fill_write_o", write_o, 0);
   endtask

   task automatic start_wb(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [LW-1:0] line, input logic also_read);
      write_i   = 1'b1;
      read_i    = also_read;
      address_i = addr;
      line_i    = line;
      done_q.push_back('{exp_addr, last_fill});
      n_issued++;
      tick();
      write_i = 1'b0;
      check("wb_write_o", write_o, 1);
      check("wb_read_o", read_o, 0);
   endtask

   task automatic run_beats(input logic [LW-1:0] data, input logic [15:0] pat,
                            input int plen, input logic is_fill);
      int k = 0;
      for (int c = 0; c < plen; c++) begin
         resp_i  = pat[c];
         burst_i = pat[c] ? data[k*BW +: BW] : 64'hDEAD_BEEF_DEAD_BEEF;
         check("busy_read_o", read_o, is_fill);
         check("busy_write_o", write_o, !is_fill);
         tick();
         if (pat[c]) k++;
      end
      resp_i  = 1'b0;
      burst_i = '0;
      check("done_resp_o", resp_o, 1);
      check("done_read_o", read_o, 0);
      check("done_write_o", write_o, 0);
      tick();
      check("after_done_resp_o", resp_o, 0);
   endtask

   logic [LW-1:0] d1, d2, d3, d4, wl;

   initial begin
      rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      address_i = '0; line_i = '0; burst_i = '0;
      #1;
      check("rst_read_o", read_o, 0);
      check("rst_write_o", write_o, 0);
      check("rst_resp_o", resp_o, 0);
      check("rst_address_o", address_o, 0);
      check("rst_burst_o", burst_o, 0);
      check("rst_line_o", line_o, 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Basic fill, resp_i continuously high.
      d1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      start_fill(32'h0000_1234, 32'h0000_1220, d1);
      check("fill_address_o", address_o, 32'h0000_1220);
      run_beats(d1, 16'h000F, 4, 1'b1);

      // Writeback: beats leave lowest slice first.
      wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      beat_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
      beat_q.push_back(64'hBBBB_BBBB_BBBB_BBBB);
      beat_q.push_back(64'hCCCC_CCCC_CCCC_CCCC);
      beat_q.push_back(64'hDDDD_DDDD_DDDD_DDDD);
      start_wb(32'hABCD_EF7F, 32'hABCD_EF60, wl, 1'b0);
      check("wb_address_o", address_o, 32'hABCD_EF60);
      run_beats(wl, 16'h000F, 4, 1'b0);

      // Fill with resp_i gaps 1,0,0,1,1,0,1.
      d2 = {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
            64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A};
      start_fill(32'h8000_001F, 32'h8000_0000, d2);
      run_beats(d2, 16'b0000_0000_0101_1001, 7, 1'b1);

      // read_i and write_i together: writeback wins, held read runs afterwards.
      wl = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
            64'h5555_5555_5555_5555, 64'hAAAA_0000_FFFF_1111};
      beat_q.push_back(64'hAAAA_0000_FFFF_1111);
      beat_q.push_back(64'h5555_5555_5555_5555);
      beat_q.push_back(64'hFEDC_BA98_7654_3210);
      beat_q.push_back(64'h0123_4567_89AB_CDEF);
      start_wb(32'h0000_2040, 32'h0000_2040, wl, 1'b1);
      run_beats(wl, 16'h000F, 4, 1'b0);
      check("both_idle_read_o", read_o, 0);
      d3 = {64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888,
            64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666};
      start_fill(32'h0000_2040, 32'h0000_2040, d3);
      run_beats(d3, 16'h000F, 4, 1'b1);

      // Reset after two of four fill beats.
      read_i = 1'b1; address_i = 32'h0000_5000;
      tick();
      read_i = 1'b0;
      resp_i = 1'b1; burst_i = 64'hEEEE_EEEE_EEEE_EEEE;
      tick(); tick();
      resp_i = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("mid_rst_read_o", read_o, 0);
      check("mid_rst_resp_o", resp_o, 0);
      check("mid_rst_address_o", address_o, 0);
      check("mid_rst_burst_o", burst_o, 0);
      check("mid_rst_line_o", line_o, 0);
      tick();
      rst = 1'b0;
      last_fill = '0;
      d4 = {64'hF4F4_F4F4_F4F4_F4F4, 64'hF3F3_F3F3_F3F3_F3F3,
            64'hF2F2_F2F2_F2F2_F2F2, 64'hF1F1_F1F1_F1F1_F1F1};
      start_fill(32'h0000_3FFF, 32'h0000_3FE0, d4);
      run_beats(d4, 16'h000F, 4, 1'b1);

      // resp_i in IDLE without a request must do nothing.
      resp_i = 1'b1; burst_i = 64'h0BAD_0BAD_0BAD_0BAD;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("idle_line_o", line_o, d4);
         check("idle_resp_o", resp_o, 0);
         check("idle_read_o", read_o, 0);
      end
      resp_i = 1'b0;

      tick(); tick();
      check("done_q_drained", 32'(done_q.size()), 0);
      check("beat_q_drained", 32'(beat_q.size()), 0);
      check("resp_count", 32'(n_resp), 32'(n_issued));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
